// File: rtl/count_pwm_if.sv
// Duty-load handshake between a duty source and count_pwm.
// The source drives data/valid; count_pwm returns ready.
interface count_pwm_if #(
   parameter int unsigned CW = 4
);
   logic [CW:0] duty_data;
   logic        duty_valid;
   logic        duty_ready;

   modport master (output duty_data, output duty_valid, input  duty_ready);
   modport slave  (input  duty_data, input  duty_valid, output duty_ready);
endinterface

// File: rtl/count_pwm.sv
// PWM stage fed by a free-running upstream counter: duty loads are applied at period wrap,
// with a wrap pulse, a period counter and a sticky non-sequential-step flag.
module count_pwm #(
   parameter int unsigned CW  = 4,
   parameter int unsigned PCW = 8
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic [CW-1:0]   cnt_val,
   count_pwm_if.slave      duty,
   input  logic            err_clr,
   output logic            pwm_out,
   output logic            wrap_pulse,
   output logic [PCW-1:0]  period_cnt,
   output logic            step_err
);

   localparam int unsigned DW = CW + 1;
   localparam logic [DW-1:0] DUTY_MAX = DW'(1) << CW;
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   prev_cnt;
   logic            prev_vld;
   logic [DW-1:0]   pend_duty;
   logic [DW-1:0]   active_duty;

   logic            wrap;
   logic            err;
   logic            xfer;
   logic            ready_c;
   logic            load_c;
   logic [DW-1:0]   duty_eff_c;
   logic [DW-1:0]   duty_sat;
   logic            pwm_nxt;

   assign wrap     = prev_vld & (prev_cnt == CNT_MAX) & (cnt_val == '0);
   assign err      = prev_vld & (cnt_val != CW'(prev_cnt + CW'(1)));
   assign xfer     = duty.duty_valid & ready_c;
   assign duty_sat = (duty.duty_data > DUTY_MAX) ? DUTY_MAX : duty.duty_data;
   assign duty.duty_ready = ready_c;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (xfer) state_nxt = PEND;
         RUN:     if (xfer) state_nxt = PEND;
         PEND:    if (wrap) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // The wrap edge that retires a pending load already compares against the new duty.
   always_comb begin
      ready_c    = (state != PEND);
      load_c     = (state == PEND) & wrap;
      duty_eff_c = load_c ? pend_duty : active_duty;
      pwm_nxt    = (state != IDLE) & ({1'b0, cnt_val} < duty_eff_c);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         prev_cnt    <= '0;
         prev_vld    <= 1'b0;
         pend_duty   <= '0;
         active_duty <= '0;
         pwm_out     <= 1'b0;
         wrap_pulse  <= 1'b0;
         period_cnt  <= '0;
         step_err    <= 1'b0;
      end else begin
         prev_cnt   <= cnt_val;
         prev_vld   <= 1'b1;
         pwm_out    <= pwm_nxt;
         wrap_pulse <= wrap;
         step_err   <= err | (step_err & ~err_clr);
         if (xfer)   pend_duty   <= duty_sat;
         if (load_c) active_duty <= pend_duty;
         if (wrap)   period_cnt  <= PCW'(period_cnt + PCW'(1));
      end
   end

endmodule

// File: tb/tb_count_pwm.sv
// Directed bench for count_pwm driven by a local free-running 4-bit counter with its own reset.
module tb_count_pwm;

   localparam int unsigned CW  = 4;
   localparam int unsigned PCW = 8;

   logic           clk;
   logic           nrst;
   logic           up_nrst;
   logic [CW-1:0]  cnt;
   logic           err_clr;
   logic           pwm_out;
   logic           wrap_pulse;
   logic [PCW-1:0] period_cnt;
   logic           step_err;

   int unsigned    total;
   int unsigned    bad;
   logic [PCW-1:0] exp_period;
   logic [CW-1:0]  last;
   logic           have_last;
   logic [PCW-1:0] p0;

   count_pwm_if #(.CW(CW)) duty ();

   count_pwm #(.CW(CW), .PCW(PCW)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .cnt_val    (cnt),
      .duty       (duty.slave),
      .err_clr    (err_clr),
      .pwm_out    (pwm_out),
      .wrap_pulse (wrap_pulse),
      .period_cnt (period_cnt),
      .step_err   (step_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Upstream free-running counter.
   always @(posedge clk or negedge up_nrst) begin
      if (!up_nrst) cnt <= '0;
      else          cnt <= cnt + 4'd1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; the wrap pulse and period count are checked against the bench's counter history.
   task automatic tick();
      logic [CW-1:0] s;
      logic          w;
      s = cnt;
      @(posedge clk);
      #1;
      w = have_last && (last == 4'd15) && (s == 4'd0);
      if (w) exp_period = exp_period + 8'd1;
      last      = s;
      have_last = 1'b1;
      chk("wrap_pulse", 32'(wrap_pulse), 32'(w));
      chk("period_cnt", 32'(period_cnt), 32'(exp_period));
   endtask

   task automatic wait_cnt(input logic [CW-1:0] v, input logic rdy);
      int n;
      n = 0;
      while (cnt != v && n < 40) begin
         chk("duty_ready_wait", 32'(duty.duty_ready), 32'(rdy));
         tick();
         n++;
      end
      chk("wait_cnt_timeout", 32'(cnt == v), 32'd1);
   endtask

   // Starting right after a wrap edge, check one full period of PWM output.
   task automatic check_period(input int n);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("pwm_d%0d_i%0d", n, i), 32'(pwm_out), 32'(i < n));
         tick();
      end
   endtask

   task automatic load_and_check(input logic [CW:0] d, input int n);
      wait_cnt(4'd8, 1'b1);
      duty.duty_data  = d;
      duty.duty_valid = 1'b1;
      tick();
      duty.duty_valid = 1'b0;
      chk("ready_after_load", 32'(duty.duty_ready), 32'd0);
      wait_cnt(4'd1, 1'b0);
      chk("ready_after_wrap", 32'(duty.duty_ready), 32'd1);
      check_period(n);
   endtask

   task automatic up_pulse();
      up_nrst = 1'b0;
      #1;
      up_nrst = 1'b1;
   endtask

   initial begin
      total = 0;
      bad = 0;
      exp_period = '0;
      last = '0;
      have_last = 1'b0;
      nrst = 1'b0;
      up_nrst = 1'b0;
      err_clr = 1'b0;
      duty.duty_data = '0;
      duty.duty_valid = 1'b0;
      #3;
      chk("rst_pwm", 32'(pwm_out), 32'd0);
      chk("rst_wrap", 32'(wrap_pulse), 32'd0);
      chk("rst_period", 32'(period_cnt), 32'd0);
      chk("rst_step_err", 32'(step_err), 32'd0);
      chk("rst_ready", 32'(duty.duty_ready), 32'd1);
      @(negedge clk);
      nrst = 1'b1;
      up_nrst = 1'b1;

      // 1: free run, no duty ever loaded
      for (int i = 0; i < 49; i++) begin
         tick();
         chk("t1_pwm", 32'(pwm_out), 32'd0);
         chk("t1_step_err", 32'(step_err), 32'd0);
         chk("t1_ready", 32'(duty.duty_ready), 32'd1);
      end
      chk("t1_period3", 32'(period_cnt), 32'd3);

      // 2: duty 5 loaded at cnt 8
      load_and_check(5'd5, 5);

      // 3: duty 0, then 16, then 20 (saturates to 16)
      load_and_check(5'd0, 0);
      load_and_check(5'd16, 16);
      load_and_check(5'd20, 16);

      // 4: duty 3 pending, duty 9 held on valid until accepted
      wait_cnt(4'd8, 1'b1);
      duty.duty_data  = 5'd3;
      duty.duty_valid = 1'b1;
      tick();
      duty.duty_data  = 5'd9;
      wait_cnt(4'd1, 1'b0);
      chk("t4_ready_wrap", 32'(duty.duty_ready), 32'd1);
      chk("t4_pwm_s0", 32'(pwm_out), 32'd1);
      tick();
      duty.duty_valid = 1'b0;
      chk("t4_ready_cap9", 32'(duty.duty_ready), 32'd0);
      chk("t4_pwm_s1", 32'(pwm_out), 32'd1);
      tick();
      chk("t4_pwm_s2", 32'(pwm_out), 32'd1);
      tick();
      chk("t4_pwm_s3", 32'(pwm_out), 32'd0);
      wait_cnt(4'd1, 1'b0);
      check_period(9);

      // 5: upstream reset at cnt 7 with duty 2 pending
      wait_cnt(4'd3, 1'b1);
      duty.duty_data  = 5'd2;
      duty.duty_valid = 1'b1;
      tick();
      duty.duty_valid = 1'b0;
      wait_cnt(4'd7, 1'b0);
      up_pulse();
      tick();
      chk("t5_step_err_set", 32'(step_err), 32'd1);
      chk("t5_ready_still_pend", 32'(duty.duty_ready), 32'd0);
      chk("t5_pwm_old_duty", 32'(pwm_out), 32'd1);
      wait_cnt(4'd0, 1'b0);
      chk("t5_step_err_sticky", 32'(step_err), 32'd1);
      tick();
      chk("t5_ready_loaded", 32'(duty.duty_ready), 32'd1);
      chk("t5_pwm_new_duty", 32'(pwm_out), 32'd1);
      wait_cnt(4'd5, 1'b1);
      up_pulse();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t5_set_beats_clr", 32'(step_err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t5_clr_alone", 32'(step_err), 32'd0);

      // 6: 256 periods wrap the period counter, then async reset while pending
      p0 = exp_period;
      for (int i = 0; i < 4096; i++) tick();
      chk("t6_period_wrapped", 32'(period_cnt), 32'(p0));
      wait_cnt(4'd8, 1'b1);
      duty.duty_data  = 5'd7;
      duty.duty_valid = 1'b1;
      tick();
      duty.duty_valid = 1'b0;
      up_pulse();
      tick();
      chk("t6_step_err_pre", 32'(step_err), 32'd1);
      chk("t6_pwm_pre", 32'(pwm_out), 32'd1);
      chk("t6_ready_pre", 32'(duty.duty_ready), 32'd0);
      #2;
      nrst = 1'b0;
      #1;
      chk("t6_rst_pwm", 32'(pwm_out), 32'd0);
      chk("t6_rst_wrap", 32'(wrap_pulse), 32'd0);
      chk("t6_rst_period", 32'(period_cnt), 32'd0);
      chk("t6_rst_step_err", 32'(step_err), 32'd0);
      chk("t6_rst_ready", 32'(duty.duty_ready), 32'd1);
      @(negedge clk);
      nrst = 1'b1;
      have_last = 1'b0;
      exp_period = '0;
      tick();
      chk("t6_idle_pwm", 32'(pwm_out), 32'd0);
      chk("t6_idle_step_err", 32'(step_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
